// File: rtl/miter_pkg.sv
// Shared types and LFSR helpers for the miter stimulus blocks.
// Galois tap masks are right-shifting: the bit shifted out of bit 0 XORs the mask into the register.
package miter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        RAND  = 2'd2,
        DONE  = 2'd3
    } t_drv_state;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    // Maximal-length tap masks for right-shifting Galois LFSRs, indexed by width.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] taps;
        case (w)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            20:      taps = 32'h0009_0000;
            24:      taps = 32'h00E1_0000;
            32:      taps = 32'hA300_0000;
            default: taps = 32'h0000_B400;
        endcase
        return taps;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] value, input int w);
        logic [31:0] shifted;
        shifted = value >> 1;
        if (value[0]) begin
            shifted = shifted ^ lfsr_taps(w);
        end
        return shifted;
    endfunction

endpackage

// File: rtl/miter_lfsr.sv
// Galois LFSR with synchronous reload; shared by the miter stimulus blocks.
module miter_lfsr
    import miter_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= SEED;
        end else if (load) begin
            r_value <= SEED;
        end else if (step) begin
            r_value <= LFSR_W'(lfsr_next(32'(r_value), LFSR_W));
        end
    end

    assign value = r_value;

endmodule

// File: rtl/miter_stim_driver.sv
// Active end of an equivalence miter: sweeps then randomises the shared input bus,
// compares the two design outputs on every accepted vector and records the verdict.
module miter_stim_driver
    import miter_pkg::*;
#(
    parameter int                DATA_W = 2,
    parameter int                Q_W    = 1,
    parameter int                N_RAND = 64,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEFAULT),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    input  logic [Q_W-1:0]    q1_i,
    input  logic [Q_W-1:0]    q2_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  mismatch_cnt_o,
    output logic [CNT_W-1:0]  vec_cnt_o,
    output logic [DATA_W-1:0] first_fail_o,
    output logic              first_fail_valid_o
);

    localparam int                RC_W       = (N_RAND > 1) ? $clog2(N_RAND) : 1;
    localparam logic [RC_W-1:0]   RAND_LAST  = RC_W'((N_RAND > 0) ? N_RAND - 1 : 0);
    localparam logic [DATA_W-1:0] SWEEP_LAST = '1;

    t_drv_state        r_state;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [CNT_W-1:0]  r_mis_cnt;
    logic [CNT_W-1:0]  r_vec_cnt;
    logic [DATA_W-1:0] r_first_fail;
    logic              r_first_fail_valid;
    logic [RC_W-1:0]   r_rand_cnt;

    logic [LFSR_W-1:0] w_lfsr_value;
    logic              w_valid;
    logic              w_accept;
    logic              w_differ;
    logic              w_last;
    logic              w_load;
    logic              w_step;
    logic [CNT_W-1:0]  w_mis_next;
    logic [CNT_W-1:0]  w_vec_next;

    assign w_valid  = (r_state == SWEEP) || (r_state == RAND);
    assign w_accept = w_valid && ready_i;
    assign w_differ = (q1_i != q2_i);
    assign w_last   = ((r_state == SWEEP) && (r_data == SWEEP_LAST)) ||
                      ((r_state == RAND)  && (r_rand_cnt == RAND_LAST));
    assign w_load   = ((r_state == IDLE) || (r_state == DONE)) && start_i;
    assign w_step   = w_accept && (r_state == RAND);

    // Next-count values feed both the counters and the pass verdict taken on the final vector.
    assign w_mis_next = (w_accept && w_differ && !(&r_mis_cnt)) ? r_mis_cnt + CNT_W'(1) : r_mis_cnt;
    assign w_vec_next = (w_accept && !(&r_vec_cnt)) ? r_vec_cnt + CNT_W'(1) : r_vec_cnt;

    miter_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .value (w_lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_data             <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_mis_cnt          <= '0;
            r_vec_cnt          <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_rand_cnt         <= '0;
        end else begin
            if (w_accept) begin
                r_vec_cnt <= w_vec_next;
                r_mis_cnt <= w_mis_next;
                if (w_differ && !r_first_fail_valid) begin
                    r_first_fail       <= r_data;
                    r_first_fail_valid <= 1'b1;
                end
            end
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state            <= SWEEP;
                        r_data             <= '0;
                        r_busy             <= 1'b1;
                        r_done             <= 1'b0;
                        r_pass             <= 1'b0;
                        r_mis_cnt          <= '0;
                        r_vec_cnt          <= '0;
                        r_first_fail       <= '0;
                        r_first_fail_valid <= 1'b0;
                        r_rand_cnt         <= '0;
                    end
                end
                SWEEP, RAND: begin
                    if (ready_i) begin
                        if (w_last && ((r_state == RAND) || (N_RAND == 0))) begin
                            r_state <= DONE;
                            r_data  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_mis_next == '0);
                        end else if (r_state == SWEEP) begin
                            if (w_last) begin
                                // The LFSR still holds SEED here, so the first random vector is the seed itself.
                                r_state <= RAND;
                                r_data  <= w_lfsr_value[DATA_W-1:0];
                            end else begin
                                r_data <= r_data + DATA_W'(1);
                            end
                        end else begin
                            r_data     <= DATA_W'(lfsr_next(32'(w_lfsr_value), LFSR_W));
                            r_rand_cnt <= r_rand_cnt + RC_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_o             = r_data;
    assign data_valid_o       = w_valid;
    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign pass_o             = r_pass;
    assign mismatch_cnt_o     = r_mis_cnt;
    assign vec_cnt_o          = r_vec_cnt;
    assign first_fail_o       = r_first_fail;
    assign first_fail_valid_o = r_first_fail_valid;

endmodule

// File: tb/tb_miter_stim_driver.sv
// Directed bench for miter_stim_driver: one instance with N_RAND=8 and one with N_RAND=0.
module tb_miter_stim_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sel;
    logic start;
    logic ready;
    int   mode_a;
    int   mode_b;

    logic        start_a, dv_a, busy_a, done_a, pass_a, ffv_a;
    logic [1:0]  data_a, ff_a;
    logic [0:0]  q1_a, q2_a;
    logic [15:0] mis_a, vec_a;
    logic        start_b, dv_b, busy_b, done_b, pass_b, ffv_b;
    logic [1:0]  data_b, ff_b;
    logic [0:0]  q1_b, q2_b;
    logic [15:0] mis_b, vec_b;

    logic        m_dv, m_busy, m_done, m_pass, m_ffv;
    logic [1:0]  m_data, m_ff;
    logic [15:0] m_mis, m_vec;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic design2(input int mode, input logic [1:0] d);
        case (mode)
            1:       return d[0];
            2:       return (d == 2'd3) ? d[0] : ~d[0];
            default: return ~d[0];
        endcase
    endfunction

    assign start_a = start && (sel == 1'b0);
    assign start_b = start && (sel == 1'b1);

    always_comb begin
        q1_a = ~data_a[0];
        q2_a = design2(mode_a, data_a);
        q1_b = ~data_b[0];
        q2_b = design2(mode_b, data_b);
    end

    always_comb begin
        if (sel == 1'b0) begin
            m_dv = dv_a; m_busy = busy_a; m_done = done_a; m_pass = pass_a; m_ffv = ffv_a;
            m_data = data_a; m_ff = ff_a; m_mis = mis_a; m_vec = vec_a;
        end else begin
            m_dv = dv_b; m_busy = busy_b; m_done = done_b; m_pass = pass_b; m_ffv = ffv_b;
            m_data = data_b; m_ff = ff_b; m_mis = mis_b; m_vec = vec_b;
        end
    end

    miter_stim_driver #(.DATA_W(2), .Q_W(1), .N_RAND(8), .LFSR_W(16), .SEED(16'hACE1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .ready_i(ready),
        .data_o(data_a), .data_valid_o(dv_a), .q1_i(q1_a), .q2_i(q2_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .mismatch_cnt_o(mis_a), .vec_cnt_o(vec_a),
        .first_fail_o(ff_a), .first_fail_valid_o(ffv_a)
    );

    miter_stim_driver #(.DATA_W(2), .Q_W(1), .N_RAND(0), .LFSR_W(16), .SEED(16'hACE1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .ready_i(ready),
        .data_o(data_b), .data_valid_o(dv_b), .q1_i(q1_b), .q2_i(q2_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .mismatch_cnt_o(mis_b), .vec_cnt_o(vec_b),
        .first_fail_o(ff_b), .first_fail_valid_o(ffv_b)
    );

    typedef struct {
        logic sel;
        int   mode;
        int   stall_at;
        int   start_mid;
        logic start_end;
        int   exp_cycles;
        logic exp_pass;
        int   exp_mis;
        int   exp_vec;
        int   exp_ff;
        logic exp_ffv;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_case(input int idx, input vec_t v);
        logic [1:0]  seq[$];
        logic [1:0]  exp_seq[$];
        logic [15:0] s;
        int          cycles;
        logic        stalled;
        sel = v.sel;
        if (v.sel == 1'b0) mode_a = v.mode; else mode_b = v.mode;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_done", 32'(m_done), 32'd0);
        check("start_clears_cnt", 32'({m_vec, m_mis}), 32'd0);
        check("start_clears_ff", 32'({m_ffv, m_pass}), 32'd0);
        check("start_first_vec", 32'({m_busy, m_dv, m_data}), 32'b1100);
        cycles  = 0;
        stalled = 1'b0;
        while (!m_done && cycles < 100) begin
            if (v.stall_at >= 0 && !stalled && m_vec == 16'(v.stall_at)) begin
                ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    cycles++;
                    check("stall_data_hold", 32'(m_data), 32'(v.stall_at));
                    check("stall_vec_hold", 32'(m_vec), 32'(v.stall_at));
                end
                ready   = 1'b1;
                stalled = 1'b1;
            end
            if (m_dv && ready) seq.push_back(m_data);
            if (v.start_mid > 0 && cycles == v.start_mid) start = 1'b1;
            if (v.start_end && m_dv && m_vec == 16'(v.exp_vec - 1)) start = 1'b1;
            tick();
            start = 1'b0;
            cycles++;
        end
        check("done_latency", 32'(cycles), 32'(v.exp_cycles));
        check("done", 32'(m_done), 32'd1);
        check("pass", 32'(m_pass), 32'(v.exp_pass));
        check("mismatch_cnt", 32'(m_mis), 32'(v.exp_mis));
        check("vec_cnt", 32'(m_vec), 32'(v.exp_vec));
        check("first_fail", 32'(m_ff), 32'(v.exp_ff));
        check("first_fail_valid", 32'(m_ffv), 32'(v.exp_ffv));
        check("done_idle_bus", 32'({m_busy, m_dv, m_data}), 32'd0);

        for (int d = 0; d < 4; d++) exp_seq.push_back(2'(d));
        if (v.sel == 1'b0) begin
            s = 16'hACE1;
            for (int k = 0; k < 8; k++) begin
                exp_seq.push_back(s[1:0]);
                s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
            end
        end
        check("seq_len", 32'(seq.size()), 32'(exp_seq.size()));
        for (int k = 0; k < exp_seq.size() && k < seq.size(); k++) begin
            check("seq_data", 32'(seq[k]), 32'(exp_seq[k]));
        end

        if (v.start_end) begin
            tick();
            check("start_at_end_ignored", 32'({m_done, m_busy}), 32'b10);
            check("start_at_end_vec", 32'(m_vec), 32'(v.exp_vec));
        end
        $display("case %0d: dut=%0d mode=%0d cycles=%0d pass=%0d mis=%0d vec=%0d ff=%0d ffv=%0d",
                 idx, v.sel, v.mode, cycles, m_pass, m_mis, m_vec, m_ff, m_ffv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            sel   mode stall mid end  cyc pass mis vec ff ffv
        tbl[0] = '{1'b0, 0,  -1,  0, 1'b0, 12, 1'b1, 0, 12, 0, 1'b0};
        tbl[1] = '{1'b0, 0,  -1,  0, 1'b0, 12, 1'b1, 0, 12, 0, 1'b0};
        tbl[2] = '{1'b0, 0,  -1,  3, 1'b0, 12, 1'b1, 0, 12, 0, 1'b0};
        tbl[3] = '{1'b0, 0,   2,  0, 1'b0, 17, 1'b1, 0, 12, 0, 1'b0};
        tbl[4] = '{1'b0, 1,  -1,  0, 1'b0, 12, 1'b0, 12, 12, 0, 1'b1};
        tbl[5] = '{1'b1, 2,  -1,  0, 1'b0, 4,  1'b0, 1, 4,  3, 1'b1};
        tbl[6] = '{1'b1, 0,  -1,  0, 1'b0, 4,  1'b1, 0, 4,  0, 1'b0};
        tbl[7] = '{1'b0, 0,  -1,  0, 1'b1, 12, 1'b1, 0, 12, 0, 1'b0};

        sel = 1'b0; start = 1'b0; ready = 1'b1; mode_a = 0; mode_b = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_a_ctrl", 32'({busy_a, done_a, pass_a, dv_a, ffv_a}), 32'd0);
        check("reset_a_data", 32'({data_a, ff_a, mis_a, vec_a}), 32'd0);
        check("reset_b_ctrl", 32'({busy_b, done_b, pass_b, dv_b, ffv_b}), 32'd0);
        check("reset_b_data", 32'({data_b, ff_b, mis_b, vec_b}), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_case(i, tbl[i]);
        end

        // Reset in the middle of the sweep abandons the run; a fresh start reruns from zero.
        sel = 1'b0; mode_a = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midrun_data", 32'(data_a), 32'd2);
        check("midrun_mis", 32'(mis_a), 32'd2);
        rst_n = 1'b0;
        tick();
        check("midrun_reset_ctrl", 32'({busy_a, done_a, pass_a, dv_a, ffv_a}), 32'd0);
        check("midrun_reset_data", 32'({data_a, ff_a, mis_a, vec_a}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("after_reset_idle", 32'({busy_a, done_a, dv_a}), 32'd0);
        $display("seq: mid-sweep reset abandoned run, rerunning");
        run_case(8, tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
